// File: rtl/periph_reg_target.sv
// periph_reg_target: peripheral-bus responder serving NumRegs R/W config registers plus an event counter.
// Latency: gnt_o after WaitCycles cycles of held req_i; r_valid_o exactly one cycle after the gnt_o cycle.
// Backpressure: stalls the initiator only through gnt_o wait states; the response has no backpressure.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/add_i/wen_i/wdata_i/be_i/id_i request,
//        gnt_o grant; r_valid_o/r_opc_o/r_rdata_o/r_id_o response; evt_i counter strobe;
//        regs_o flattened config registers, reg k at [k*DataWidth +: DataWidth].
module periph_reg_target #(
  parameter int                   AddrWidth   = 32,
  parameter int                   DataWidth   = 32,
  parameter int                   IdWidth     = 5,
  parameter int                   NumRegs     = 8,
  parameter int                   WaitCycles  = 0,
  parameter logic [DataWidth-1:0] RegResetVal = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic [AddrWidth-1:0]           add_i,
  input  logic                           wen_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic [DataWidth/8-1:0]         be_i,
  input  logic [IdWidth-1:0]             id_i,
  output logic                           gnt_o,
  output logic                           r_valid_o,
  output logic                           r_opc_o,
  output logic [DataWidth-1:0]           r_rdata_o,
  output logic [IdWidth-1:0]             r_id_o,
  input  logic                           evt_i,
  output logic [NumRegs*DataWidth-1:0]   regs_o
);

  localparam int BeW  = DataWidth / 8;
  localparam int IdxW = $clog2(NumRegs + 1);
  localparam int CntW = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     wcnt_q, wcnt_d;
  logic                gnt;
  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] evt_cnt_q;
  logic [DataWidth-1:0] rd_val;
  logic [IdxW-1:0]     idx;
  logic                is_reg, is_cnt, is_err;

  // Slot decoding happens upstream; only the word index matters here.
  logic unused_addr;
  assign unused_addr = ^{add_i[AddrWidth-1:2+IdxW], add_i[1:0]};

  assign idx    = add_i[2 +: IdxW];
  assign is_reg = idx < IdxW'(NumRegs);
  assign is_cnt = idx == IdxW'(NumRegs);
  assign is_err = !is_reg && !is_cnt;

  function automatic logic [DataWidth-1:0] byte_merge(input logic [DataWidth-1:0] old_v,
                                                      input logic [DataWidth-1:0] new_v,
                                                      input logic [BeW-1:0]       be);
    logic [DataWidth-1:0] res;
    res = old_v;
    for (int b = 0; b < BeW; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Next-state / grant. RESP accepts a new request exactly like IDLE so
  // zero-wait initiators can issue back to back.
  always_comb begin
    state_d = IDLE;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (req_i) begin
          if (WaitCycles == 0) begin
            gnt     = 1'b1;
            state_d = RESP;
          end else begin
            wcnt_d  = CntW'(WaitCycles - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          // Initiator withdrew before grant: abandon silently.
          state_d = IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d  = wcnt_q - 1'b1;
          state_d = WAIT;
        end else begin
          gnt     = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Read mux sees pre-edge values, so a read returns state before any same-edge update.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NumRegs; k++) begin
      if (idx == IdxW'(k)) rd_val = regs_q[k];
    end
    if (is_cnt) rd_val = evt_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_opc_o   <= 1'b0;
      r_rdata_o <= '0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= gnt;
      if (gnt) begin
        r_opc_o   <= is_err;
        r_rdata_o <= (wen_i && !is_err) ? rd_val : '0;
        r_id_o    <= id_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumRegs; k++) regs_q[k] <= RegResetVal;
    end else if (gnt && !wen_i && is_reg) begin
      for (int k = 0; k < NumRegs; k++) begin
        if (idx == IdxW'(k)) regs_q[k] <= byte_merge(regs_q[k], wdata_i, be_i);
      end
    end
  end

  // A granted write wins over the event strobe; that cycle's increment is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_cnt_q <= '0;
    end else if (gnt && !wen_i && is_cnt) begin
      evt_cnt_q <= byte_merge(evt_cnt_q, wdata_i, be_i);
    end else if (evt_i) begin
      evt_cnt_q <= evt_cnt_q + 1'b1;
    end
  end

  assign gnt_o = gnt;

  for (genvar g = 0; g < NumRegs; g++) begin : g_regs_out
    assign regs_o[g*DataWidth +: DataWidth] = regs_q[g];
  end

endmodule

// File: tb/tb_periph_reg_target.sv
// Testbench for periph_reg_target: zero-wait instance driven through a response scoreboard,
// plus a three-wait-state instance for grant timing, withdrawn requests and reset in RESP.
module tb_periph_reg_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait instance
  logic        rst0_n, req0, wen0, gnt0, r_valid0, r_opc0, evt0;
  logic [31:0] add0, wdata0, r_rdata0;
  logic [3:0]  be0;
  logic [4:0]  id0, r_id0;
  logic [255:0] regs0;

  // Three-wait-state instance
  logic        rst3_n, req3, wen3, gnt3, r_valid3, r_opc3, evt3;
  logic [31:0] add3, wdata3, r_rdata3;
  logic [3:0]  be3;
  logic [4:0]  id3, r_id3;
  logic [255:0] regs3;

  periph_reg_target #(.WaitCycles(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .req_i(req0), .add_i(add0), .wen_i(wen0),
    .wdata_i(wdata0), .be_i(be0), .id_i(id0), .gnt_o(gnt0), .r_valid_o(r_valid0),
    .r_opc_o(r_opc0), .r_rdata_o(r_rdata0), .r_id_o(r_id0), .evt_i(evt0), .regs_o(regs0)
  );

  periph_reg_target #(.WaitCycles(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .req_i(req3), .add_i(add3), .wen_i(wen3),
    .wdata_i(wdata3), .be_i(be3), .id_i(id3), .gnt_o(gnt3), .r_valid_o(r_valid3),
    .r_opc_o(r_opc3), .r_rdata_o(r_rdata3), .r_id_o(r_id3), .evt_i(evt3), .regs_o(regs3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        opc;
    logic [4:0]  id;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mdl [8];
  logic [31:0] cnt_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One granted request on the zero-wait instance; the expected response is queued.
  task automatic req0_step(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] b, input logic [4:0] i, input logic e);
    int   ix;
    rsp_t r;
    @(negedge clk);
    req0 = 1'b1; add0 = a; wen0 = w; wdata0 = d; be0 = b; id0 = i; evt0 = e;
    #1 chk("gnt0", gnt0, 1'b1);
    ix      = int'(a[5:2]);
    r.id    = i;
    r.opc   = (ix > 8);
    r.rdata = '0;
    if (ix < 8) begin
      if (w) r.rdata = mdl[ix];
      else   mdl[ix] = merge(mdl[ix], d, b);
    end else if (ix == 8) begin
      if (w) r.rdata = cnt_exp;
      else   cnt_exp = merge(cnt_exp, d, b);
    end
    if (e && !(ix == 8 && !w)) cnt_exp = cnt_exp + 32'd1;
    sb.push_back(r);
  endtask

  task automatic idle0(input int n, input logic e);
    repeat (n) begin
      @(negedge clk);
      req0 = 1'b0; evt0 = e;
      if (e) cnt_exp = cnt_exp + 32'd1;
    end
  endtask

  task automatic chk_regs();
    for (int k = 0; k < 8; k++)
      chk($sformatf("regs0[%0d]", k), regs0[k*32 +: 32], mdl[k]);
  endtask

  // Response monitor: every r_valid0 must match the oldest queued expectation.
  always @(negedge clk) begin
    rsp_t r;
    if (rst0_n && r_valid0) begin
      chk("rsp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("r_rdata0", r_rdata0, r.rdata);
        chk("r_opc0",   r_opc0,   r.opc);
        chk("r_id0",    r_id0,    r.id);
      end
    end
  end

  initial begin
    rst0_n = 0; req0 = 0; add0 = 0; wen0 = 0; wdata0 = 0; be0 = 0; id0 = 0; evt0 = 0;
    rst3_n = 0; req3 = 0; add3 = 0; wen3 = 0; wdata3 = 0; be3 = 0; id3 = 0; evt3 = 0;
    for (int k = 0; k < 8; k++) mdl[k] = 32'h0;
    cnt_exp = 32'h0;

    repeat (2) @(negedge clk);
    rst0_n = 1; rst3_n = 1;
    @(negedge clk);
    chk("rst_gnt0",     gnt0,     1'b0);
    chk("rst_r_valid0", r_valid0, 1'b0);
    chk("rst_r_opc0",   r_opc0,   1'b0);
    chk("rst_r_rdata0", r_rdata0, 32'h0);
    chk("rst_r_id0",    r_id0,    5'h0);
    chk_regs();

    // Counter reads 0 out of reset
    req0_step(32'h20, 1, 32'h0, 4'h0, 5'd1, 0);
    // Back-to-back write then read
    req0_step(32'h04, 0, 32'hDEADBEEF, 4'hF, 5'd3, 0);
    req0_step(32'h04, 1, 32'h0, 4'h0, 5'd4, 0);
    idle0(2, 0);
    chk_regs();

    // Partial byte write
    req0_step(32'h08, 0, 32'h11223344, 4'hF, 5'd5, 0);
    req0_step(32'h08, 0, 32'hAABBCCDD, 4'h5, 5'd6, 0);
    req0_step(32'h08, 1, 32'h0, 4'h0, 5'd7, 0);
    idle0(2, 0);
    chk("reg2_partial", regs0[64 +: 32], 32'h11BB33DD);

    // Event counter: increments, write priority, wrap, pre-increment read
    idle0(10, 1);
    req0_step(32'h20, 1, 32'h0, 4'h0, 5'd8, 0);
    req0_step(32'h20, 0, 32'hFFFFFFFF, 4'hF, 5'd9, 1);
    idle0(1, 1);
    req0_step(32'h20, 1, 32'h0, 4'h0, 5'd10, 0);
    req0_step(32'h20, 0, 32'h5, 4'hF, 5'd11, 1);
    req0_step(32'h20, 1, 32'h0, 4'h0, 5'd12, 1);
    req0_step(32'h20, 1, 32'h0, 4'h0, 5'd13, 0);

    // Out-of-range accesses and empty byte enable
    req0_step(32'h24, 1, 32'h0, 4'h0, 5'd14, 0);
    req0_step(32'h3C, 0, 32'hFFFFFFFF, 4'hF, 5'd15, 0);
    req0_step(32'h04, 0, 32'h0, 4'h0, 5'd16, 0);
    req0_step(32'h04, 1, 32'h0, 4'h0, 5'd17, 0);
    idle0(3, 0);
    chk_regs();

    // Wait-state instance: grant at t+3, response at t+4
    @(negedge clk);
    req3 = 1; add3 = 32'h08; wen3 = 1; id3 = 5'd7;
    for (int k = 0; k < 4; k++) begin
      #1 chk("gnt3_timing", gnt3, (k == 3));
      chk("r_valid3_early", r_valid3, 1'b0);
      @(negedge clk);
    end
    req3 = 0;
    chk("r_valid3",  r_valid3, 1'b1);
    chk("r_rdata3",  r_rdata3, 32'h0);
    chk("r_opc3",    r_opc3,   1'b0);
    chk("r_id3",     r_id3,    5'd7);
    @(negedge clk);
    chk("r_valid3_one_cycle", r_valid3, 1'b0);

    // Withdrawn request: no grant, no response
    req3 = 1; id3 = 5'd9;
    @(negedge clk);
    req3 = 0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("gnt3_dropped", gnt3, 1'b0);
      chk("r_valid3_dropped", r_valid3, 1'b0);
      @(negedge clk);
    end

    // FSM back in IDLE: a fresh request sees the full wait again; reset kills the response
    req3 = 1; id3 = 5'd11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("gnt3_retry", gnt3, (k == 3));
      @(negedge clk);
    end
    req3 = 0;
    chk("r_valid3_retry", r_valid3, 1'b1);
    rst3_n = 0;
    #1 chk("r_valid3_rst", r_valid3, 1'b0);
    chk("r_id3_rst", r_id3, 5'd0);
    @(negedge clk);
    rst3_n = 1;
    @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
